// File: rtl/exception_controller_pkg.sv
// Shared definitions for the exception sequencer: state encoding, cause bit
// positions and the default kernel handler entry address.
package exception_controller_pkg;

  typedef enum logic [1:0] {
    USER   = 2'd0,
    ENTER  = 2'd1,
    KERNEL = 2'd2,
    RETURN = 2'd3
  } excState_t;

  localparam int CAUSE_OVF = 0;
  localparam int CAUSE_USR = 1;

  localparam logic [15:0] HANDLER_ADDR_DEFAULT = 16'h0100;

endpackage

// File: rtl/exception_controller.sv
// Exception/interrupt sequencer: captures EPC and cause, redirects to the kernel
// handler, and restores PC and interrupt enable on rfe.
module exception_controller
  import exception_controller_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 16,
  parameter logic [DATA_WIDTH-1:0] HANDLER_ADDR = DATA_WIDTH'(HANDLER_ADDR_DEFAULT)
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  mode,
  input  logic                  overflow,
  input  logic                  userInput,
  input  logic [DATA_WIDTH-1:0] pcCurrent,
  input  logic                  setIE,
  input  logic                  clearIE,
  input  logic                  rfe,
  output logic                  interruptsEnabled,
  output logic                  kernelMode,
  output logic                  pcOverride,
  output logic [DATA_WIDTH-1:0] pcTarget,
  output logic                  flushPipe,
  output logic [DATA_WIDTH-1:0] epc,
  output logic [1:0]            cause,
  output logic                  inputAck
);

  excState_t state;
  excState_t nextState;
  logic      savedIE;

  // State register plus the architectural registers; only USER samples the
  // exception inputs, so a userInput held late is not re-latched in the handler.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state             <= USER;
      interruptsEnabled <= 1'b0;
      savedIE           <= 1'b0;
      epc               <= '0;
      cause             <= 2'b00;
    end else begin
      state <= nextState;
      case (state)
        USER: begin
          if (mode) begin
            epc              <= pcCurrent;
            cause[CAUSE_USR] <= userInput;
            cause[CAUSE_OVF] <= overflow;
            savedIE          <= interruptsEnabled;
            interruptsEnabled <= 1'b0;
          end else if (clearIE) begin
            interruptsEnabled <= 1'b0;
          end else if (setIE) begin
            interruptsEnabled <= 1'b1;
          end
        end
        RETURN: begin
          interruptsEnabled <= savedIE;
          cause             <= 2'b00;
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs depend on state (and registered epc/cause) only, never on inputs.
  always_comb begin
    nextState  = state;
    kernelMode = 1'b0;
    pcOverride = 1'b0;
    flushPipe  = 1'b0;
    pcTarget   = '0;
    inputAck   = 1'b0;
    case (state)
      USER: begin
        if (mode) nextState = ENTER;
      end
      ENTER: begin
        kernelMode = 1'b1;
        pcOverride = 1'b1;
        flushPipe  = 1'b1;
        pcTarget   = HANDLER_ADDR;
        inputAck   = cause[CAUSE_USR];
        nextState  = KERNEL;
      end
      KERNEL: begin
        kernelMode = 1'b1;
        if (rfe) nextState = RETURN;
      end
      RETURN: begin
        kernelMode = 1'b1;
        pcOverride = 1'b1;
        flushPipe  = 1'b1;
        pcTarget   = epc;
        nextState  = USER;
      end
      default: nextState = USER;
    endcase
  end

endmodule
